// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types: bus request/response, FSM states, PC update ops,
// and the IF/ID payload that decode consumes.
package fetch_ctrl_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] inst_t;

  localparam addr_t PCINIT = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    inst_t data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    REQ,
    DATA,
    HOLD
  } fetch_state_t;

  // Operations the PC register block can perform in one cycle.
  typedef enum logic [2:0] {
    PC_KEEP,
    PC_INCR,
    PC_REDIRECT,
    PC_KILL,
    PC_RESUME
  } pc_op_t;

  // IF/ID payload handed to decode.
  typedef struct packed {
    addr_t pc;
    inst_t inst;
    logic  misalign;
  } if_id_t;

  function automatic logic is_misaligned(addr_t a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-bus interface: the fetch controller is the master, memory the slave.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;

  modport master (output ireq, input iresp);
  modport slave  (input ireq, output iresp);
endinterface

// File: rtl/fetch_pc_reg.sv
// PC bookkeeping: current fetch PC, the deferred redirect target and the
// kill flag that marks an in-flight transaction as stale.
module fetch_pc_reg
  import fetch_ctrl_pkg::*;
#(
  parameter addr_t RESET_PC = PCINIT
) (
  input  logic   clk,
  input  logic   rst,
  input  pc_op_t op,
  input  addr_t  redirect_pc,
  output addr_t  pc,
  output logic   kill
);

  addr_t pend_pc;

  // Apply the selected PC operation; a kill defers the redirect until the bus completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      pend_pc <= '0;
      kill    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      case (op)
        PC_INCR:     pc <= pc + 64'd4;
        PC_REDIRECT: begin
          pc   <= redirect_pc;
          kill <= 1'b0;
        end
        PC_KILL: begin
          kill    <= 1'b1;
          pend_pc <= redirect_pc;
        end
        PC_RESUME: begin
          pc   <= pend_pc;
          kill <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding ibus request, valid/ready
// hand-off to decode, and redirect absorption including mid-transaction.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter addr_t RESET_PC = PCINIT,
  parameter inst_t NOP_INST = 32'h0000_0013
) (
  input  logic  clk,
  input  logic  rst,
  fetch_ctrl_if.master ibus,
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  output logic  if_valid,
  input  logic  if_ready,
  output addr_t if_pc,
  output inst_t if_inst,
  output logic  if_misalign
);

  fetch_state_t state_q, state_d;
  pc_op_t       pc_op;
  addr_t        pc;
  logic         kill;
  inst_t        inst_q;
  logic         inst_we;
  logic         pc_misaligned;
  logic         req_valid;
  logic         in_flight;
  logic         complete;
  if_id_t       if_out;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .op          (pc_op),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .kill        (kill)
  );

  assign pc_misaligned = is_misaligned(pc);
  // A misaligned PC never reaches the bus; it is turned into a NOP fault in HOLD.
  assign req_valid     = (state_q == REQ) && !pc_misaligned;
  // Once valid is up the transaction is committed, so it counts as in flight.
  assign in_flight     = req_valid || (state_q == DATA);
  assign complete      = (req_valid && ibus.iresp.addr_ok && ibus.iresp.data_ok) ||
                         ((state_q == DATA) && ibus.iresp.data_ok);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= REQ;
    else      state_q <= state_d;
  end

  // Fetched-instruction latch.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: inst_q is a single register, not a memory array, so it is reset to
    // give a defined if_inst of zero straight out of reset.
    if (!rst)         inst_q <= '0;
    else if (inst_we) inst_q <= ibus.iresp.data;
  end

  // Next-state and PC-operation selection.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    pc_op   = PC_KEEP;
    inst_we = 1'b0;
    if (in_flight) begin
      if (complete) begin
        if (redirect_valid) begin
          pc_op   = PC_REDIRECT;
          state_d = REQ;
        end else if (kill) begin
          pc_op   = PC_RESUME;
          state_d = REQ;
        end else begin
          inst_we = 1'b1;
          state_d = HOLD;
        end
      end else begin
        if (req_valid && ibus.iresp.addr_ok) state_d = DATA;
        if (redirect_valid)                  pc_op   = PC_KILL;
      end
    end else if (state_q == HOLD) begin
      if (redirect_valid) begin
        pc_op   = PC_REDIRECT;
        state_d = REQ;
      end else if (if_ready) begin
        pc_op   = PC_INCR;
        state_d = REQ;
      end
    end else begin
      // REQ with a misaligned PC: no bus request, present a fault instead.
      if (redirect_valid) pc_op   = PC_REDIRECT;
      else                state_d = HOLD;
    end
  end

  // valid is gated by reset so it drops the moment reset asserts.
  assign ibus.ireq = '{valid: req_valid & rst, addr: pc};

  assign if_out = '{
    pc:       pc,
    inst:     ((state_q == HOLD) && pc_misaligned) ? NOP_INST : inst_q,
    misalign: (state_q == HOLD) && pc_misaligned
  };

  assign if_valid    = (state_q == HOLD) && !redirect_valid;
  assign if_pc       = if_out.pc;
  assign if_inst     = if_out.inst;
  assign if_misalign = if_out.misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a latency-programmable ibus responder, a decode-side
// scoreboard of expected deliveries, and one task per scenario.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam addr_t BASE = 64'h0000_0000_8000_0000;
  localparam inst_t NOP  = 32'h0000_0013;

  logic  clk = 1'b0;
  logic  rst;
  logic  redirect_valid;
  addr_t redirect_pc;
  logic  if_valid;
  logic  if_ready;
  addr_t if_pc;
  inst_t if_inst;
  logic  if_misalign;

  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(BASE), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .ibus           (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_misalign    (if_misalign)
  );

  typedef struct {
    addr_t pc;
    inst_t inst;
    logic  mis;
  } exp_t;

  exp_t  sb[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    n_deliv  = 0;
  int    addr_lat = 0;
  int    data_lat = 0;
  logic  ready_q  = 1'b0;
  bit    in_data, req_seen, hold_pending, model_kill;
  int    wait_cnt, dcnt;
  addr_t req_addr, hold_addr;

  function automatic inst_t mem_word(addr_t a);
    if (a == BASE) return 32'h0050_0093;
    return {a[15:2], 2'b00, 16'h0113};
  endfunction

  task automatic model_reset();
    in_data = 0; req_seen = 0; hold_pending = 0; model_kill = 0;
    wait_cnt = 0; dcnt = 0;
    sb.delete();
  endtask

  // One clock: respond on the bus, drive decode/redirect, then check deliveries.
  task automatic tick(input bit rdv = 1'b0, input addr_t rpc = '0);
    ibus_resp_t r;
    bit completing, in_flight;
    exp_t e;
    @(negedge clk);
    r = '0;
    completing = 0;
    in_flight = in_data || (bus.ireq.valid === 1'b1);
    if (hold_pending) begin
      n_assert++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== hold_addr) begin
        n_fail++;
        $display("FAIL req_stable: valid=%b addr=%h, required valid=1 addr=%h",
                 bus.ireq.valid, bus.ireq.addr, hold_addr);
      end
    end
    if (in_data) begin
      n_assert++;
      if (bus.ireq.valid !== 1'b0) begin
        n_fail++;
        $display("FAIL one_outstanding: valid=%b during data phase, required 0", bus.ireq.valid);
      end
      dcnt--;
      if (dcnt == 0) begin r.data_ok = 1'b1; completing = 1; end
    end else if (bus.ireq.valid === 1'b1) begin
      if (!req_seen) begin req_seen = 1; wait_cnt = addr_lat; req_addr = bus.ireq.addr; end
      if (wait_cnt == 0) begin
        r.addr_ok = 1'b1;
        req_seen  = 0;
        if (data_lat == 0) begin r.data_ok = 1'b1; completing = 1; end
        else begin in_data = 1; dcnt = data_lat; end
      end else begin
        wait_cnt--;
      end
    end
    hold_pending = (bus.ireq.valid === 1'b1) && !r.addr_ok;
    hold_addr    = bus.ireq.addr;
    if (completing) begin
      in_data = 0;
      r.data  = mem_word(req_addr);
      if (!(model_kill || rdv)) sb.push_back('{pc: req_addr, inst: r.data, mis: 1'b0});
      model_kill = 0;
    end else if (rdv && in_flight) begin
      model_kill = 1;
    end
    if (rdv && !in_flight) sb.delete();
    bus.iresp      = r;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    if_ready       = ready_q;
    #1;
    if (if_valid === 1'b1 && if_ready === 1'b1) begin
      n_deliv++;
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL delivery: got pc=%h inst=%h, required no instruction", if_pc, if_inst);
      end else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_inst !== e.inst || if_misalign !== e.mis) begin
          n_fail++;
          $display("FAIL delivery: got pc=%h inst=%h mis=%b, required pc=%h inst=%h mis=%b",
                   if_pc, if_inst, if_misalign, e.pc, e.inst, e.mis);
        end
      end
    end
  endtask

  // Stop in HOLD with one instruction presented and not accepted.
  task automatic park();
    bit ok = 0;
    ready_q = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (if_valid === 1'b1) ok = 1;
    end
    n_assert++;
    if (!ok || sb.size() != 1) begin
      n_fail++;
      $display("FAIL park: if_valid=%b queued=%0d, required 1 and 1 within 30 cycles", if_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    bus.iresp = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_assert++;
    if (bus.ireq.valid !== 1'b0 || if_valid !== 1'b0 || if_pc !== BASE ||
        if_inst !== 32'h0 || if_misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b if_valid=%b pc=%h inst=%h mis=%b, required 0 0 %h 0 0",
               bus.ireq.valid, if_valid, if_pc, if_inst, if_misalign, BASE);
    end
    @(posedge clk); #2 rst = 1'b1;
  endtask

  task automatic test_basic();
    int n0;
    ready_q = 1'b1;
    tick();
    n_assert++;
    if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== BASE) begin
      n_fail++;
      $display("FAIL basic_first_req: valid=%b addr=%h, required 1 %h", bus.ireq.valid, bus.ireq.addr, BASE);
    end
    tick();
    n_assert++;
    if (if_valid !== 1'b1 || if_pc !== BASE || if_inst !== 32'h0050_0093) begin
      n_fail++;
      $display("FAIL basic_first_inst: if_valid=%b pc=%h inst=%h, required 1 %h 00500093",
               if_valid, if_pc, if_inst, BASE);
    end
    tick();
    n_assert++;
    if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== BASE + 64'd4) begin
      n_fail++;
      $display("FAIL basic_second_req: valid=%b addr=%h, required 1 %h", bus.ireq.valid, bus.ireq.addr, BASE + 64'd4);
    end
    n0 = n_deliv;
    repeat (6) tick();
    n_assert++;
    if (n_deliv - n0 != 3) begin
      n_fail++;
      $display("FAIL basic_throughput: delivered %0d in 6 cycles, required 3", n_deliv - n0);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    park();
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      tick();
      n_assert++;
      if (if_valid !== 1'b1 || if_pc !== e.pc || if_inst !== e.inst || bus.ireq.valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: if_valid=%b pc=%h inst=%h req=%b, required 1 %h %h 0",
                 if_valid, if_pc, if_inst, bus.ireq.valid, e.pc, e.inst);
      end
    end
    ready_q = 1'b1;
    tick();
    tick();
    n_assert++;
    if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== e.pc + 64'd4) begin
      n_fail++;
      $display("FAIL stall_next_req: valid=%b addr=%h, required 1 %h", bus.ireq.valid, bus.ireq.addr, e.pc + 64'd4);
    end
  endtask

  task automatic test_slow_bus();
    exp_t e;
    int   n0;
    park();
    e = sb[0];
    ready_q = 1'b1; addr_lat = 3; data_lat = 2;
    tick();
    n0 = n_deliv;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (t < 4) begin
        n_assert++;
        if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== e.pc + 64'd4) begin
          n_fail++;
          $display("FAIL slow_req_hold: cycle %0d valid=%b addr=%h, required 1 %h",
                   t, bus.ireq.valid, bus.ireq.addr, e.pc + 64'd4);
        end
      end else if (t < 6) begin
        n_assert++;
        if (bus.ireq.valid !== 1'b0) begin
          n_fail++;
          $display("FAIL slow_data_phase: cycle %0d valid=%b, required 0", t, bus.ireq.valid);
        end
      end
    end
    n_assert++;
    if (n_deliv - n0 != 1) begin
      n_fail++;
      $display("FAIL slow_count: delivered %0d, required 1", n_deliv - n0);
    end
    addr_lat = 0; data_lat = 0;
  endtask

  task automatic test_redirect_data();
    exp_t e;
    park();
    e = sb[0];
    ready_q = 1'b1; data_lat = 3;
    tick();
    tick();
    n_assert++;
    if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== e.pc + 64'd4) begin
      n_fail++;
      $display("FAIL redir_data_req: valid=%b addr=%h, required 1 %h", bus.ireq.valid, bus.ireq.addr, e.pc + 64'd4);
    end
    tick(1'b1, BASE + 64'h100);
    tick();
    tick();
    data_lat = 0;
    tick();
    n_assert++;
    if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== BASE + 64'h100 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_data_restart: valid=%b addr=%h if_valid=%b, required 1 %h 0",
               bus.ireq.valid, bus.ireq.addr, if_valid, BASE + 64'h100);
    end
    tick();
    n_assert++;
    if (if_valid !== 1'b1 || if_pc !== BASE + 64'h100) begin
      n_fail++;
      $display("FAIL redir_data_deliver: if_valid=%b pc=%h, required 1 %h", if_valid, if_pc, BASE + 64'h100);
    end
  endtask

  task automatic test_double_redirect();
    exp_t e;
    park();
    e = sb[0];
    ready_q = 1'b1; addr_lat = 3; data_lat = 2;
    tick();
    tick(1'b1, BASE + 64'h100);
    tick();
    tick(1'b1, BASE + 64'h200);
    n_assert++;
    if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== e.pc + 64'd4) begin
      n_fail++;
      $display("FAIL dbl_addr_unchanged: valid=%b addr=%h, required 1 %h", bus.ireq.valid, bus.ireq.addr, e.pc + 64'd4);
    end
    repeat (3) tick();
    addr_lat = 0; data_lat = 0;
    tick();
    n_assert++;
    if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== BASE + 64'h200) begin
      n_fail++;
      $display("FAIL dbl_restart: valid=%b addr=%h, required 1 %h", bus.ireq.valid, bus.ireq.addr, BASE + 64'h200);
    end
    tick();
    n_assert++;
    if (if_valid !== 1'b1 || if_pc !== BASE + 64'h200) begin
      n_fail++;
      $display("FAIL dbl_deliver: if_valid=%b pc=%h, required 1 %h", if_valid, if_pc, BASE + 64'h200);
    end
  endtask

  task automatic test_misalign();
    park();
    ready_q = 1'b0;
    tick(1'b1, BASE + 64'h102);
    n_assert++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_redirect_cycle: if_valid=%b, required 0", if_valid);
    end
    sb.push_back('{pc: BASE + 64'h102, inst: NOP, mis: 1'b1});
    tick();
    n_assert++;
    if (bus.ireq.valid !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_no_req: valid=%b if_valid=%b, required 0 0", bus.ireq.valid, if_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_assert++;
      if (bus.ireq.valid !== 1'b0 || if_valid !== 1'b1 || if_misalign !== 1'b1 ||
          if_inst !== NOP || if_pc !== BASE + 64'h102) begin
        n_fail++;
        $display("FAIL mis_hold: req=%b if_valid=%b mis=%b inst=%h pc=%h, required 0 1 1 %h %h",
                 bus.ireq.valid, if_valid, if_misalign, if_inst, if_pc, NOP, BASE + 64'h102);
      end
    end
    ready_q = 1'b1;
    tick();
    ready_q = 1'b0;
    tick(1'b1, BASE + 64'h300);
    n_assert++;
    if (bus.ireq.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_after_accept: valid=%b, required 0", bus.ireq.valid);
    end
    tick();
    n_assert++;
    if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== BASE + 64'h300) begin
      n_fail++;
      $display("FAIL mis_escape: valid=%b addr=%h, required 1 %h", bus.ireq.valid, bus.ireq.addr, BASE + 64'h300);
    end
  endtask

  task automatic test_async_reset();
    park();
    ready_q = 1'b1; addr_lat = 3;
    tick();
    tick();
    n_assert++;
    if (bus.ireq.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: valid=%b, required 1", bus.ireq.valid);
    end
    #2 rst = 1'b0;
    #1;
    n_assert++;
    if (bus.ireq.valid !== 1'b0 || if_valid !== 1'b0 || if_pc !== BASE) begin
      n_fail++;
      $display("FAIL arst_immediate: valid=%b if_valid=%b pc=%h, required 0 0 %h",
               bus.ireq.valid, if_valid, if_pc, BASE);
    end
    model_reset();
    bus.iresp = '0;
    addr_lat = 0; data_lat = 0;
    @(posedge clk); #2 rst = 1'b1;
    tick();
    n_assert++;
    if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== BASE) begin
      n_fail++;
      $display("FAIL arst_restart: valid=%b addr=%h, required 1 %h", bus.ireq.valid, bus.ireq.addr, BASE);
    end
    tick();
    n_assert++;
    if (if_valid !== 1'b1 || if_pc !== BASE || if_inst !== 32'h0050_0093) begin
      n_fail++;
      $display("FAIL arst_first_inst: if_valid=%b pc=%h inst=%h, required 1 %h 00500093",
               if_valid, if_pc, if_inst, BASE);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_slow_bus();
    test_redirect_data();
    test_double_redirect();
    test_misalign();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
